// File: rtl/player_pkg.sv
// Shared encodings for the fighter controller: state codes, hit_flag and
// atk_active values, and the phase-length helper used by the timers.
package player_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FWD       = 4'd1,
      ST_BACK      = 4'd2,
      ST_B_START   = 4'd3,
      ST_B_ACT     = 4'd4,
      ST_B_REC     = 4'd5,
      ST_D_START   = 4'd6,
      ST_D_ACT     = 4'd7,
      ST_D_REC     = 4'd8,
      ST_HITSTUN   = 4'd9,
      ST_BLOCKSTUN = 4'd10,
      ST_KO        = 4'd11
   } state_e;

   localparam logic [1:0] HIT_NONE  = 2'b00;
   localparam logic [1:0] HIT_BASIC = 2'b01;
   localparam logic [1:0] HIT_DIR   = 2'b10;

   localparam logic [1:0] ATK_NONE  = 2'b00;
   localparam logic [1:0] ATK_BASIC = 2'b01;
   localparam logic [1:0] ATK_DIR   = 2'b10;

   // A zero-length phase would never expire, so it is stretched to one frame.
   function automatic int unsigned phase_len(input int unsigned n);
      return (n == 0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-based phase down-counter: loads on a tick, otherwise counts down on
// each tick and flags the tick on which the count is 1.
module frame_timer #(
   parameter int TMR_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [TMR_W-1:0] value_i,
   output logic             expire_o
);

   logic [TMR_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (tick_i) begin
         if (load_i) begin
            count_d = value_i;
         end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = tick_i && (count_q == TMR_W'(1));

endmodule

// File: rtl/player_fsm_v2.sv
// One player's fighter controller: movement, basic/directional attacks,
// hit and block stun, health and KO, all advancing on frame_tick only.
module player_fsm_v2
   import player_pkg::*;
#(
   parameter int unsigned SIDE      = 0,
   parameter int unsigned X_START   = 100,
   parameter int unsigned Y_POS     = 170,
   parameter int unsigned X_MIN     = 5,
   parameter int unsigned X_MAX     = 495,
   parameter int unsigned SPD_FWD   = 3,
   parameter int unsigned SPD_BACK  = 2,
   parameter int unsigned KNOCKBACK = 1,
   parameter int unsigned B_STARTUP = 5,
   parameter int unsigned B_ACTIVE  = 2,
   parameter int unsigned B_RECOVER = 16,
   parameter int unsigned D_STARTUP = 5,
   parameter int unsigned D_ACTIVE  = 2,
   parameter int unsigned D_RECOVER = 16,
   parameter int unsigned HSTUN_B   = 15,
   parameter int unsigned HSTUN_D   = 14,
   parameter int unsigned BSTUN_B   = 13,
   parameter int unsigned BSTUN_D   = 12,
   parameter int unsigned HP_MAX    = 100,
   parameter int unsigned DMG_B     = 8,
   parameter int unsigned DMG_D     = 12,
   parameter int          HP_W      = 7,
   parameter int          TMR_W     = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            frame_tick,
   input  logic            left,
   input  logic            right,
   input  logic            attack,
   input  logic [1:0]      hit_flag,
   output logic [9:0]      posx,
   output logic [9:0]      posy,
   output logic [3:0]      state,
   output logic [HP_W-1:0] health,
   output logic            ko,
   output logic [1:0]      atk_active
);

   localparam logic [TMR_W-1:0] L_BS = TMR_W'(phase_len(B_STARTUP));
   localparam logic [TMR_W-1:0] L_BA = TMR_W'(phase_len(B_ACTIVE));
   localparam logic [TMR_W-1:0] L_BR = TMR_W'(phase_len(B_RECOVER));
   localparam logic [TMR_W-1:0] L_DS = TMR_W'(phase_len(D_STARTUP));
   localparam logic [TMR_W-1:0] L_DA = TMR_W'(phase_len(D_ACTIVE));
   localparam logic [TMR_W-1:0] L_DR = TMR_W'(phase_len(D_RECOVER));
   localparam logic [TMR_W-1:0] L_HB = TMR_W'(phase_len(HSTUN_B));
   localparam logic [TMR_W-1:0] L_HD = TMR_W'(phase_len(HSTUN_D));
   localparam logic [TMR_W-1:0] L_KB = TMR_W'(phase_len(BSTUN_B));
   localparam logic [TMR_W-1:0] L_KD = TMR_W'(phase_len(BSTUN_D));

   localparam logic [HP_W-1:0] HP_INIT = HP_W'(HP_MAX);
   localparam logic [HP_W-1:0] DMG_BV  = HP_W'(DMG_B);
   localparam logic [HP_W-1:0] DMG_DV  = HP_W'(DMG_D);

   localparam logic [10:0] XMIN11 = 11'(X_MIN);
   localparam logic [10:0] XMAX11 = 11'(X_MAX);
   localparam logic [10:0] STEP_F = 11'(SPD_FWD);
   localparam logic [10:0] STEP_B = 11'(SPD_BACK);
   localparam logic [10:0] STEP_K = 11'(KNOCKBACK);
   localparam logic        FWD_IS_NEG = (SIDE != 0);

   state_e          state_q, state_d, decode_st;
   logic [9:0]      posx_q, posx_d;
   logic [HP_W-1:0] health_q, health_d, dmg;
   logic            ko_q, ko_d;
   logic            hit_valid, hit_basic, hit_reload, atk_basic;
   logic            fwd_key, back_key;
   logic            tmr_load, tmr_expire;
   logic [TMR_W-1:0] tmr_val;
   logic            mv_en, mv_neg;
   logic [10:0]     step, pos_ext, pos_sum, pos_clamp;

   assign hit_valid = (hit_flag == HIT_BASIC) || (hit_flag == HIT_DIR);
   assign hit_basic = (hit_flag == HIT_BASIC);
   assign dmg       = hit_basic ? DMG_BV : DMG_DV;
   assign fwd_key   = (SIDE != 0) ? left  : right;
   assign back_key  = (SIDE != 0) ? right : left;

   // Attack flavour depends on where the decode happens, not on the direction keys.
   assign atk_basic = (state_q == ST_IDLE)    || (state_q == ST_HITSTUN) ||
                      (state_q == ST_BLOCKSTUN) || (state_q == ST_B_REC);

   always_comb begin
      decode_st = ST_IDLE;
      if (attack) begin
         decode_st = atk_basic ? ST_B_START : ST_D_START;
      end else if (left && right) begin
         decode_st = ST_BACK;
      end else if (fwd_key) begin
         decode_st = ST_FWD;
      end else if (back_key) begin
         decode_st = ST_BACK;
      end
   end

   always_comb begin
      state_d    = state_q;
      health_d   = health_q;
      ko_d       = ko_q;
      hit_reload = 1'b0;
      if (frame_tick && !ko_q) begin
         if (hit_valid) begin
            if ((state_q == ST_BACK) || (state_q == ST_BLOCKSTUN)) begin
               state_d    = ST_BLOCKSTUN;
               hit_reload = 1'b1;
            end else begin
               health_d = (health_q > dmg) ? (health_q - dmg) : '0;
               if (health_d == '0) begin
                  state_d = ST_KO;
                  ko_d    = 1'b1;
               end else begin
                  state_d    = ST_HITSTUN;
                  hit_reload = 1'b1;
               end
            end
         end else begin
            case (state_q)
               ST_IDLE, ST_FWD, ST_BACK: state_d = decode_st;
               ST_B_START: if (tmr_expire) state_d = ST_B_ACT;
               ST_B_ACT:   if (tmr_expire) state_d = ST_B_REC;
               ST_D_START: if (tmr_expire) state_d = ST_D_ACT;
               ST_D_ACT:   if (tmr_expire) state_d = ST_D_REC;
               ST_B_REC, ST_D_REC, ST_HITSTUN, ST_BLOCKSTUN:
                  if (tmr_expire) state_d = decode_st;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // Untimed states load 0 so the counter idles there instead of free-running.
   always_comb begin
      tmr_load = hit_reload || (state_d != state_q);
      case (state_d)
         ST_B_START:   tmr_val = L_BS;
         ST_B_ACT:     tmr_val = L_BA;
         ST_B_REC:     tmr_val = L_BR;
         ST_D_START:   tmr_val = L_DS;
         ST_D_ACT:     tmr_val = L_DA;
         ST_D_REC:     tmr_val = L_DR;
         ST_HITSTUN:   tmr_val = hit_basic ? L_HB : L_HD;
         ST_BLOCKSTUN: tmr_val = hit_basic ? L_KB : L_KD;
         default:      tmr_val = '0;
      endcase
   end

   frame_timer #(
      .TMR_W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (frame_tick),
      .load_i   (tmr_load),
      .value_i  (tmr_val),
      .expire_o (tmr_expire)
   );

   always_comb begin
      mv_en  = 1'b0;
      mv_neg = 1'b0;
      step   = '0;
      case (state_d)
         ST_FWD: begin
            mv_en  = 1'b1;
            mv_neg = FWD_IS_NEG;
            step   = STEP_F;
         end
         ST_BACK: begin
            mv_en  = 1'b1;
            mv_neg = !FWD_IS_NEG;
            step   = STEP_B;
         end
         ST_HITSTUN: begin
            mv_en  = 1'b1;
            mv_neg = !FWD_IS_NEG;
            step   = STEP_K;
         end
         default: mv_en = 1'b0;
      endcase
   end

   // Underflow is caught before subtracting so the 11-bit result never wraps.
   always_comb begin
      pos_ext = {1'b0, posx_q};
      if (mv_neg) begin
         pos_sum = (pos_ext > step) ? (pos_ext - step) : '0;
      end else begin
         pos_sum = pos_ext + step;
      end
      if (pos_sum < XMIN11) begin
         pos_clamp = XMIN11;
      end else if (pos_sum > XMAX11) begin
         pos_clamp = XMAX11;
      end else begin
         pos_clamp = pos_sum;
      end
      posx_d = posx_q;
      if (frame_tick && mv_en) begin
         posx_d = pos_clamp[9:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         posx_q   <= 10'(X_START);
         health_q <= HP_INIT;
         ko_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         posx_q   <= posx_d;
         health_q <= health_d;
         ko_q     <= ko_d;
      end
   end

   assign posx   = posx_q;
   assign posy   = 10'(Y_POS);
   assign state  = state_q;
   assign health = health_q;
   assign ko     = ko_q;

   always_comb begin
      case (state_q)
         ST_B_ACT: atk_active = ATK_BASIC;
         ST_D_ACT: atk_active = ATK_DIR;
         default:  atk_active = ATK_NONE;
      endcase
   end

endmodule

// File: tb/tb_player_fsm_v2.sv
// Bench for player_fsm_v2: three instances (default, low-HP, right-side)
// share one input stream and are checked against a frame-level game model.
module tb_player_fsm_v2;

   localparam int S_IDLE = 0, S_FWD = 1, S_BACK = 2, S_BST = 3, S_BACT = 4, S_BREC = 5;
   localparam int S_DST = 6, S_DACT = 7, S_DREC = 8, S_HIT = 9, S_BLK = 10, S_KO = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_tick = 1'b0;
   logic left = 1'b0, right = 1'b0, attack = 1'b0;
   logic [1:0] hit_flag = 2'b00;

   logic [2:0][9:0] posx_w, posy_w;
   logic [2:0][3:0] state_w;
   logic [2:0][6:0] health_w;
   logic [2:0]      ko_w;
   logic [2:0][1:0] atk_w;

   int side_p [3] = '{0, 0, 1};
   int hp_p   [3] = '{100, 10, 100};

   int m_st [3];
   int m_px [3];
   int m_hp [3];
   int m_rem[3];
   bit m_ko [3];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   player_fsm_v2 dut0 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .left(left), .right(right),
      .attack(attack), .hit_flag(hit_flag), .posx(posx_w[0]), .posy(posy_w[0]),
      .state(state_w[0]), .health(health_w[0]), .ko(ko_w[0]), .atk_active(atk_w[0])
   );

   player_fsm_v2 #(.HP_MAX(10), .DMG_B(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .left(left), .right(right),
      .attack(attack), .hit_flag(hit_flag), .posx(posx_w[1]), .posy(posy_w[1]),
      .state(state_w[1]), .health(health_w[1]), .ko(ko_w[1]), .atk_active(atk_w[1])
   );

   player_fsm_v2 #(.SIDE(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .left(left), .right(right),
      .attack(attack), .hit_flag(hit_flag), .posx(posx_w[2]), .posy(posy_w[2]),
      .state(state_w[2]), .health(health_w[2]), .ko(ko_w[2]), .atk_active(atk_w[2])
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   task automatic decode(input int cur, input int side, output int ns, output int nr);
      bit fk, bk;
      fk = (side != 0) ? left : right;
      bk = (side != 0) ? right : left;
      nr = 0;
      if (attack) begin
         ns = (cur == S_IDLE || cur == S_HIT || cur == S_BLK || cur == S_BREC) ? S_BST : S_DST;
         nr = 5;
      end else if (left && right) ns = S_BACK;
      else if (fk) ns = S_FWD;
      else if (bk) ns = S_BACK;
      else ns = S_IDLE;
   endtask

   task automatic model_tick(input int i);
      int ns, nr, d, p, dir;
      bit hv;
      if (m_ko[i]) return;
      hv = (hit_flag == 2'b01) || (hit_flag == 2'b10);
      ns = m_st[i];
      nr = m_rem[i];
      if (hv) begin
         if (m_st[i] == S_BACK || m_st[i] == S_BLK) begin
            ns = S_BLK;
            nr = (hit_flag == 2'b01) ? 13 : 12;
         end else begin
            d = (hit_flag == 2'b01) ? 8 : 12;
            m_hp[i] = (m_hp[i] > d) ? m_hp[i] - d : 0;
            if (m_hp[i] == 0) begin
               ns = S_KO;
               m_ko[i] = 1'b1;
            end else begin
               ns = S_HIT;
               nr = (hit_flag == 2'b01) ? 15 : 14;
            end
         end
      end else if (m_st[i] == S_IDLE || m_st[i] == S_FWD || m_st[i] == S_BACK) begin
         decode(m_st[i], side_p[i], ns, nr);
      end else if (m_rem[i] == 1) begin
         case (m_st[i])
            S_BST:   begin ns = S_BACT; nr = 2;  end
            S_BACT:  begin ns = S_BREC; nr = 16; end
            S_DST:   begin ns = S_DACT; nr = 2;  end
            S_DACT:  begin ns = S_DREC; nr = 16; end
            default: decode(m_st[i], side_p[i], ns, nr);
         endcase
      end else begin
         nr = m_rem[i] - 1;
      end
      // Forward is +x for the left player and -x for the right player.
      dir = (side_p[i] != 0) ? -1 : 1;
      if (ns == S_FWD || ns == S_BACK || ns == S_HIT) begin
         p = m_px[i] + ((ns == S_FWD) ? 3 * dir : (ns == S_BACK) ? -2 * dir : -dir);
         if (p < 5) p = 5;
         if (p > 495) p = 495;
         m_px[i] = p;
      end
      m_st[i]  = ns;
      m_rem[i] = nr;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_st[i] = S_IDLE; m_px[i] = 100; m_hp[i] = hp_p[i]; m_rem[i] = 0; m_ko[i] = 1'b0;
         end
      end else if (frame_tick) begin
         for (int i = 0; i < 3; i++) model_tick(i);
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d.state", i), int'(state_w[i]), m_st[i]);
            check($sformatf("d%0d.posx", i), int'(posx_w[i]), m_px[i]);
            check($sformatf("d%0d.health", i), int'(health_w[i]), m_hp[i]);
            check($sformatf("d%0d.ko", i), int'(ko_w[i]), int'(m_ko[i]));
            check($sformatf("d%0d.atk", i), int'(atk_w[i]),
                  (m_st[i] == S_BACT) ? 1 : (m_st[i] == S_DACT) ? 2 : 0);
            check($sformatf("d%0d.posy", i), int'(posy_w[i]), 170);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic do_tick(input logic l, input logic r, input logic a, input logic [1:0] h);
      left = l; right = r; attack = a; hit_flag = h; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0; hit_flag = 2'b00;
      @(negedge clk);
   endtask

   task automatic ticks(input int n, input logic l, input logic r);
      for (int k = 0; k < n; k++) do_tick(l, r, 1'b0, 2'b00);
   endtask

   initial begin
      // clock/reset
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      check("rst.posx", int'(posx_w[0]), 100);
      check("rst.health", int'(health_w[0]), 100);
      check("rst.state", int'(state_w[0]), 0);
      check("rst.ko", int'(ko_w[0]), 0);
      check("rst.health_lowhp", int'(health_w[1]), 10);

      ticks(10, 1'b1, 1'b0);
      check("left10.state", int'(state_w[0]), 2);
      check("left10.posx", int'(posx_w[0]), 80);
      check("left10.side1_state", int'(state_w[2]), 1);
      check("left10.side1_posx", int'(posx_w[2]), 70);
      ticks(50, 1'b1, 1'b0);
      check("left60.posx_clamp", int'(posx_w[0]), 5);
      check("left60.side1_clamp", int'(posx_w[2]), 5);

      ticks(1, 1'b0, 1'b0);
      do_tick(1'b0, 1'b0, 1'b1, 2'b00);
      check("atk.start", int'(state_w[0]), 3);
      ticks(4, 1'b0, 1'b0);
      check("atk.start_hold", int'(state_w[0]), 3);
      ticks(1, 1'b0, 1'b0);
      check("atk.active", int'(state_w[0]), 4);
      check("atk.active_flag", int'(atk_w[0]), 1);
      ticks(2, 1'b0, 1'b0);
      check("atk.rec", int'(state_w[0]), 5);
      ticks(3, 1'b0, 1'b0);
      left = 1'b1; attack = 1'b1;
      repeat (100) @(negedge clk);
      check("atk.frozen", int'(state_w[0]), 5);
      ticks(12, 1'b0, 1'b0);
      check("atk.rec_last", int'(state_w[0]), 5);
      ticks(1, 1'b0, 1'b0);
      check("atk.done", int'(state_w[0]), 0);

      ticks(10, 1'b0, 1'b1);
      check("right10.posx", int'(posx_w[0]), 35);
      check("right10.side1_posx", int'(posx_w[2]), 25);
      ticks(1, 1'b0, 1'b0);
      do_tick(1'b0, 1'b0, 1'b0, 2'b01);
      check("hit.state", int'(state_w[0]), 9);
      check("hit.health", int'(health_w[0]), 92);
      check("hit.posx", int'(posx_w[0]), 34);
      check("hit.lowhp", int'(health_w[1]), 2);
      ticks(4, 1'b0, 1'b0);
      check("hit.knock4", int'(posx_w[0]), 30);
      do_tick(1'b0, 1'b0, 1'b0, 2'b10);
      check("combo.health", int'(health_w[0]), 80);
      check("combo.posx", int'(posx_w[0]), 29);
      check("ko.health", int'(health_w[1]), 0);
      check("ko.flag", int'(ko_w[1]), 1);
      check("ko.state", int'(state_w[1]), 11);
      ticks(13, 1'b0, 1'b0);
      check("combo.still_stun", int'(state_w[0]), 9);
      check("combo.posx_end", int'(posx_w[0]), 16);
      ticks(1, 1'b0, 1'b0);
      check("combo.exit", int'(state_w[0]), 0);

      ticks(1, 1'b1, 1'b0);
      do_tick(1'b1, 1'b0, 1'b0, 2'b10);
      check("block.state", int'(state_w[0]), 10);
      check("block.health", int'(health_w[0]), 80);
      ticks(11, 1'b1, 1'b0);
      check("block.hold", int'(state_w[0]), 10);
      ticks(1, 1'b1, 1'b0);
      check("block.exit_back", int'(state_w[0]), 2);
      check("block.posx", int'(posx_w[0]), 12);
      check("ko.sticky", int'(state_w[1]), 11);

      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rstko.health", int'(health_w[1]), 10);
      check("rstko.ko", int'(ko_w[1]), 0);
      check("rstko.state", int'(state_w[1]), 0);
      check("rstko.posx", int'(posx_w[0]), 100);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);

      ticks(5, 1'b0, 1'b1);
      check("side1.back_state", int'(state_w[2]), 2);
      check("side1.back_posx", int'(posx_w[2]), 110);
      check("side0.fwd_posx", int'(posx_w[0]), 115);
      do_tick(1'b0, 1'b0, 1'b1, 2'b01);
      check("hit_vs_atk.state", int'(state_w[0]), 9);
      check("hit_vs_atk.health", int'(health_w[0]), 92);

      // randomized stream
      for (int c = 0; c < 3000; c++) begin
         frame_tick = ($urandom_range(0, 2) != 0);
         left       = ($urandom_range(0, 2) == 0);
         right      = ($urandom_range(0, 2) == 0);
         attack     = ($urandom_range(0, 5) == 0);
         hit_flag   = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 499) == 0) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            #3 rst_n = 1'b1;
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/player_fsm_v2.md
Name: player_fsm_v2

Overview:
- Parametrised second-generation fighter controller: movement, two attack types, hit/block stun, health and KO for one player.
- Timing is frame-based. Every state timer advances only on a frame_tick strobe, so all durations are in frames, not clocks.
- Sits between input debouncing and the hitbox/collision/render logic. Hitbox geometry is generated downstream from posx/posy/state/SIDE.

Parameters:
- SIDE, 0, 0 = left player (forward is +x), 1 = right player (forward is −x)
- X_START, 100, posx after reset
- Y_POS, 170, constant posy
- X_MIN, 5, lowest legal posx
- X_MAX, 495, highest legal posx
- SPD_FWD, 3, px per frame when moving forward
- SPD_BACK, 2, px per frame when moving backward
- KNOCKBACK, 1, px per frame pushed backward during HITSTUN
- B_STARTUP / B_ACTIVE / B_RECOVER, 5 / 2 / 16, basic attack phase lengths in frames
- D_STARTUP / D_ACTIVE / D_RECOVER, 5 / 2 / 16, directional attack phase lengths in frames
- HSTUN_B / HSTUN_D, 15 / 14, hitstun frames after a basic / directional hit
- BSTUN_B / BSTUN_D, 13 / 12, blockstun frames after a blocked basic / directional hit
- HP_MAX, 100, starting health
- DMG_B / DMG_D, 8 / 12, damage per unblocked hit
- HP_W, 7, health width
- TMR_W, 6, phase timer width

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-clock strobe per game frame
- left, right, attack, in, 1 each, player inputs, level-sensitive
- hit_flag, in, 2, 00 none, 01 basic hit, 10 directional hit, 11 treated as 00
- posx, out, 10, player x position
- posy, out, 10, constant Y_POS
- state, out, 4, current state encoding
- health, out, HP_W, remaining health
- ko, out, 1, high once health reaches 0
- atk_active, out, 2, 01 basic hitbox live, 10 directional hitbox live, 00 otherwise

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, posx=X_START, health=HP_MAX, timer=0, ko=0, atk_active=00.
  - A reset mid-attack or mid-stun aborts it immediately.
- State encoding: IDLE 0, FWD 1, BACK 2, B_START 3, B_ACT 4, B_REC 5, D_START 6, D_ACT 7, D_REC 8, HITSTUN 9, BLOCKSTUN 10, KO 11.
- Evaluation: all state, posx, health and timer updates occur only on clocks with frame_tick=1. Otherwise everything holds.
- Timed states: on entry the timer is loaded with N, the phase length. Each tick in the state decrements it. The state exits on the tick where the timer equals 1.
  - A state entered on tick k is therefore exited on tick k+N.
  - A parameter of 0 is treated as 1.
- Tick priority, highest first:
  - ko → stay in KO.
  - Valid hit_flag → hit handling.
  - Timed-state expiry.
  - Input decode.
- Hit handling:
  - In BACK or BLOCKSTUN: enter BLOCKSTUN with BSTUN_x frames; health unchanged.
  - In any other non-KO state: enter HITSTUN with HSTUN_x frames; health −= DMG_x.
  - A hit already in HITSTUN is a combo: reload the timer and apply damage again.
- Health: subtraction saturates at 0. When health reaches 0 on a tick, the next state is KO and ko=1, sticky until reset.
- Input decode (IDLE, FWD, BACK, and on expiry of REC/HITSTUN/BLOCKSTUN):
  - attack → attack start. The attack is basic from IDLE, HITSTUN, BLOCKSTUN and B_REC; directional from FWD, BACK and D_REC.
  - left&right → BACK.
  - Toward-opponent key alone → FWD; away key alone → BACK. For SIDE=0, right is forward; for SIDE=1, left is forward.
  - No input → IDLE.
- Attack sequences: B_START→B_ACT→B_REC and D_START→D_ACT→D_REC. Attacks ignore direction inputs until recovery expires.
- atk_active: combinational from state. It is 01 in B_ACT, 10 in D_ACT, 00 otherwise.
- posx update, applied on a tick according to the next state:
  - FWD: move by SPD_FWD forward.
  - BACK: move by SPD_BACK backward.
  - HITSTUN: move by KNOCKBACK backward.
  - All other states: hold.
  - Results clamp to [X_MIN, X_MAX] and never wrap. Compute in 11 bits, then saturate.
- All internal timer and stun values are registered; no combinational self-assignment.

Decomposition:
- Shared package player_pkg:
  - state localparams.
  - hit_flag encodings.
  - atk_active encodings.
- Sub-module frame_timer: TMR_W down-counter with load/value/tick inputs and an `expire` output (tick & count==1).
- The FSM and position datapath stay in player_fsm_v2.

Test Plan:
- Reset → posx=100, health=100, state=0, ko=0. Hold left with SIDE=0 for 10 ticks → state=2, posx=80. Hold 50 more ticks → posx clamps at 5.
- From IDLE, attack=1 for one tick → B_START for 5 ticks, B_ACT for 2 ticks (atk_active=01), B_REC for 16 ticks, then IDLE. Toggling frame_tick off for 100 clocks mid-phase must not change state.
- hit_flag=01 while IDLE → HITSTUN, health=92, posx decreases by 1 per tick for 15 ticks. hit_flag=10 on tick 5 of the stun → timer reloads to 14 and health=80.
- BACK held, hit_flag=10 → BLOCKSTUN for 12 ticks, health unchanged. left still held at expiry → BACK.
- Override HP_MAX=10, DMG_B=8: two basic hits → health saturates at 0, KO with ko=1. Further hits and inputs are ignored. rst_n pulsed low mid-KO → full reset values.
- SIDE=1 with right held → posx increases by 2 per tick (BACK). Simultaneous hit_flag and attack on the same tick → HITSTUN wins.
